// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam int REPEAT_DELAY = 32;
    localparam int REPEAT_RATE  = 8;

    function automatic logic [3:0] code_of(
        input logic [1:0] row_idx,
        input logic [1:0] col_idx
    );
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module row_sync (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    import keypad_pkg::*;

    logic [3:0] r_s1;
    logic [3:0] r_s2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= COL_IDLE;
            r_s2 <= COL_IDLE;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/keypad_scan_4x4.sv
// Scanned 4x4 keypad with press/release debounce and one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of key_valid while held.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CNT);

    state_t        r_state;
    logic          r_active;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [1:0]    r_prow;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic          r_valid;
    logic          r_held;

    state_t        w_state_nx;
    logic [SW-1:0] w_slot_nx;
    logic [1:0]    w_col_nx;
    logic [1:0]    w_prow_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_code_nx;
    logic          w_valid_nx;
    logic          w_held_nx;

    logic [3:0]    w_rows;
    logic          w_sample;
    logic          w_any;
    logic [1:0]    w_hit;
    logic          w_pend_low;
    logic [CW-1:0] w_cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    logic [5:0] r_rep;
    logic [5:0] w_rep_nx;
    logic [5:0] w_rep_inc;
    assign w_rep_inc = r_rep + 6'd1;
`endif

    row_sync u_sync (
        .i_clk   (sys_clk),
        .i_rst_n (reset),
        .i_d     (key_row),
        .o_q     (w_rows)
    );

    assign w_sample   = r_active && (r_slot == SLOT_LAST);
    assign w_any      = ~&w_rows;
    assign w_pend_low = ~w_rows[r_prow];
    assign w_cnt_inc  = r_cnt + CW'(1);

    // Lowest-numbered active row wins
    always_comb begin
        w_hit = 2'd0;
        if (!w_rows[0])      w_hit = 2'd0;
        else if (!w_rows[1]) w_hit = 2'd1;
        else if (!w_rows[2]) w_hit = 2'd2;
        else if (!w_rows[3]) w_hit = 2'd3;
    end

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_prow_nx  = r_prow;
        w_cnt_nx   = r_cnt;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        w_held_nx  = r_held;
        w_slot_nx  = '0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nx   = r_rep;
`endif
        if (r_active) begin
            w_slot_nx = (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
        end

        if (w_sample) begin
            unique case (r_state)
                SCAN: begin
                    if (w_any) begin
                        w_prow_nx = w_hit;
                        if (CNT_DONE == CW'(1)) begin
                            w_code_nx  = code_of(w_hit, r_col);
                            w_valid_nx = 1'b1;
                            w_held_nx  = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
                            w_rep_nx   = '0;
`endif
                        end else begin
                            w_cnt_nx   = CW'(1);
                            w_state_nx = DEBOUNCE;
                        end
                    end else begin
                        w_col_nx = r_col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_pend_low) begin
                        w_cnt_nx   = '0;
                        w_col_nx   = r_col + 2'd1;
                        w_state_nx = SCAN;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_code_nx  = code_of(r_prow, r_col);
                        w_valid_nx = 1'b1;
                        w_held_nx  = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_nx   = '0;
`endif
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                HELD: begin
                    if (!w_pend_low && w_cnt_inc == CNT_DONE) begin
                        w_held_nx  = 1'b0;
                        w_cnt_nx   = '0;
                        w_col_nx   = r_col + 2'd1;
                        w_state_nx = SCAN;
                    end else begin
                        w_cnt_nx = w_pend_low ? '0 : w_cnt_inc;
`ifdef KEYPAD_REPEAT_EN
                        // After the first repeat, rewind so the next fires RATE samples later
                        if (w_rep_inc == 6'(REPEAT_DELAY)) begin
                            w_valid_nx = 1'b1;
                            w_rep_nx   = 6'(REPEAT_DELAY - REPEAT_RATE);
                        end else begin
                            w_rep_nx = w_rep_inc;
                        end
`endif
                    end
                end
                default: w_state_nx = SCAN;
            endcase
        end

        if (!enable) begin
            w_state_nx = SCAN;
            w_col_nx   = 2'd0;
            w_cnt_nx   = '0;
            w_slot_nx  = '0;
            w_held_nx  = 1'b0;
            w_valid_nx = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            w_rep_nx   = '0;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state  <= SCAN;
            r_active <= 1'b0;
            r_slot   <= '0;
            r_col    <= 2'd0;
            r_prow   <= 2'd0;
            r_cnt    <= '0;
            r_code   <= 4'h0;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep    <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_active <= enable;
            r_slot   <= w_slot_nx;
            r_col    <= w_col_nx;
            r_prow   <= w_prow_nx;
            r_cnt    <= w_cnt_nx;
            r_code   <= w_code_nx;
            r_valid  <= w_valid_nx;
            r_held   <= w_held_nx;
`ifdef KEYPAD_REPEAT_EN
            r_rep    <= w_rep_nx;
`endif
        end
    end

    assign key_col   = r_active ? ~(4'b0001 << r_col) : COL_IDLE;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule
